// File: rtl/ext_mem_responder_if.sv
// ---------------------------------------------------------------------------
// ext_mem_responder_if
// Strobe-protocol external bus between a CPU-side master and the memory
// responder. All strobes are active low.
//   addr    : word address from the master
//   din     : write data, [7:0] lane 0, [15:8] lane 1
//   rdn     : read strobe
//   wr0n    : lane-0 write strobe
//   wr1n    : lane-1 write strobe
//   dout    : read data from the responder
//   dout_en : read data valid / bus driver enable
//   busy    : responder has a transaction in progress
//   err     : sticky protocol-error flag
// ---------------------------------------------------------------------------
interface ext_mem_responder_if;
  logic [15:0] addr;
  logic [15:0] din;
  logic        rdn;
  logic        wr0n;
  logic        wr1n;
  logic [15:0] dout;
  logic        dout_en;
  logic        busy;
  logic        err;

  modport master (
    output addr, din, rdn, wr0n, wr1n,
    input  dout, dout_en, busy, err
  );

  modport slave (
    input  addr, din, rdn, wr0n, wr1n,
    output dout, dout_en, busy, err
  );
endinterface

// File: rtl/ext_mem_responder.sv
// ---------------------------------------------------------------------------
// ext_mem_responder
// Target end of the external strobe bus: serves reads and byte-lane writes
// from an internal 2^ADDR_BITS x 16 word store inside a decoded address
// window, with programmable read latency, write-lane accumulation and a
// sticky protocol-error flag.
// Ports:
//   clk : system clock, all state on the rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of ext_mem_responder_if (addr/din/strobes in,
//         dout/dout_en/busy/err out)
// ---------------------------------------------------------------------------
module ext_mem_responder #(
  parameter logic [15:0] ADDR_BASE    = 16'h8000,
  parameter int          ADDR_BITS    = 10,
  parameter int          READ_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  ext_mem_responder_if.slave  bus
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY - 1);

  // ERR_DRAIN holds the bus off after a protocol error until every strobe
  // has been released, so a half-finished transaction is never resumed.
  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_ACC,
    ERR_DRAIN
  } state_t;

  state_t                 r_state, w_stateNext;
  logic                   r_rdnQ, r_wr0nQ, r_wr1nQ;
  logic [15:0]            r_mem [DEPTH];
  logic [ADDR_BITS-1:0]   r_idx, w_idxNext;
  logic [15:0]            r_wrData, w_wrDataNext;
  logic [1:0]             r_mask, w_maskNext;
  logic [3:0]             r_cnt, w_cntNext;
  logic [15:0]            r_dout, w_doutNext;
  logic                   r_doutEn, w_doutEnNext;
  logic                   r_err, w_errNext;

  logic                   w_hit;
  logic [ADDR_BITS-1:0]   w_index;
  logic [1:0]             w_lanesLow;
  logic                   w_rdLow, w_wrLow, w_rdFall, w_wrFall;
  logic                   w_fault, w_commit;

  assign w_hit      = (bus.addr[15:ADDR_BITS] == ADDR_BASE[15:ADDR_BITS]);
  assign w_index    = bus.addr[ADDR_BITS-1:0];
  assign w_lanesLow = {~bus.wr1n, ~bus.wr0n};
  assign w_rdLow    = ~bus.rdn;
  assign w_wrLow    = |w_lanesLow;
  // A falling strobe is a low sample whose previous sample was high.
  assign w_rdFall   = r_rdnQ & ~bus.rdn;
  assign w_wrFall   = (r_wr0nQ & ~bus.wr0n) | (r_wr1nQ & ~bus.wr1n);

  // Next-state and datapath decisions for every state. Any protocol
  // violation raises w_fault, which overrides the per-state result below
  // so the transaction is dropped in one place.
  always_comb begin
    w_stateNext  = r_state;
    w_idxNext    = r_idx;
    w_wrDataNext = r_wrData;
    w_maskNext   = r_mask;
    w_cntNext    = r_cnt;
    w_doutNext   = r_dout;
    w_doutEnNext = r_doutEn;
    w_errNext    = r_err;
    w_fault      = 1'b0;
    w_commit     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_hit && (w_rdFall || w_wrFall)) begin
          if (w_rdLow && w_wrLow) begin
            w_fault = 1'b1;
          end else if (w_rdFall) begin
            w_idxNext = w_index;
            if (READ_LATENCY == 1) begin
              w_doutNext   = r_mem[w_index];
              w_doutEnNext = 1'b1;
              w_stateNext  = RD_DRIVE;
            end else begin
              w_cntNext   = LAT_LOAD;
              w_stateNext = RD_WAIT;
            end
          end else begin
            // The opening edge already counts as an accumulation sample.
            w_idxNext    = w_index;
            w_wrDataNext = bus.din;
            w_maskNext   = w_lanesLow;
            w_stateNext  = WR_ACC;
          end
        end
      end

      RD_WAIT: begin
        if (w_wrFall || (w_rdLow && w_wrLow)) begin
          w_fault = 1'b1;
        end else if (!w_rdLow) begin
          w_stateNext = IDLE;
        end else if (r_cnt == 4'd0) begin
          w_doutNext   = r_mem[r_idx];
          w_doutEnNext = 1'b1;
          w_stateNext  = RD_DRIVE;
        end else begin
          w_cntNext = r_cnt - 4'd1;
        end
      end

      RD_DRIVE: begin
        if (w_wrFall || (w_rdLow && w_wrLow)) begin
          w_fault = 1'b1;
        end else if (!w_rdLow) begin
          w_doutEnNext = 1'b0;
          w_stateNext  = IDLE;
        end
      end

      WR_ACC: begin
        if (w_rdLow) begin
          w_fault = 1'b1;
        end else if (w_wrLow) begin
          w_idxNext    = w_index;
          w_wrDataNext = bus.din;
          w_maskNext   = r_mask | w_lanesLow;
        end else begin
          w_commit    = 1'b1;
          w_maskNext  = 2'b00;
          w_stateNext = IDLE;
        end
      end

      ERR_DRAIN: begin
        if (!w_rdLow && !w_wrLow) begin
          w_stateNext = IDLE;
        end
      end

      default: w_stateNext = IDLE;
    endcase

    if (w_fault) begin
      w_errNext    = 1'b1;
      w_doutEnNext = 1'b0;
      w_maskNext   = 2'b00;
      w_commit     = 1'b0;
      w_stateNext  = ERR_DRAIN;
    end
  end

  // State, strobe history and datapath registers. Strobe history resets
  // high so a strobe already low when reset drops is seen as a new edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rdnQ   <= 1'b1;
      r_wr0nQ  <= 1'b1;
      r_wr1nQ  <= 1'b1;
      r_idx    <= '0;
      r_wrData <= 16'h0000;
      r_mask   <= 2'b00;
      r_cnt    <= 4'd0;
      r_dout   <= 16'h0000;
      r_doutEn <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_rdnQ   <= bus.rdn;
      r_wr0nQ  <= bus.wr0n;
      r_wr1nQ  <= bus.wr1n;
      r_idx    <= w_idxNext;
      r_wrData <= w_wrDataNext;
      r_mask   <= w_maskNext;
      r_cnt    <= w_cntNext;
      r_dout   <= w_doutNext;
      r_doutEn <= w_doutEnNext;
      r_err    <= w_errNext;
    end
  end

  // Word store: deliberately not reset, only the lanes collected during
  // the write transaction are updated.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      if (r_mask[0]) r_mem[r_idx][7:0]  <= r_wrData[7:0];
      if (r_mask[1]) r_mem[r_idx][15:8] <= r_wrData[15:8];
    end
  end

  assign bus.dout    = r_dout;
  assign bus.dout_en = r_doutEn;
  assign bus.busy    = (r_state != IDLE);
  assign bus.err     = r_err;

endmodule
